// File: rtl/alu_pkg.sv
// alu_pkg: opcodes shared with the ALU control decoder and the exec FSM states
package alu_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/alu_logic_core.sv
// alu_logic_core: single-cycle and/or/add/sub/slt; barrel shifts when ALU_EXEC_FAST_SHIFT_EN is defined
module alu_logic_core #(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ALU_EXEC_FAST_SHIFT_EN
    input  logic [$clog2(WIDTH)-1:0] shamt,
`endif
    output logic [WIDTH-1:0] y
);
    import alu_pkg::*;
    always_comb begin
        y = '0;
        case (op)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
`ifdef ALU_EXEC_FAST_SHIFT_EN
            ALU_SLL: y = a << shamt;
            ALU_SRL: y = a >> shamt;
`endif
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: EX-stage ALU with start/done handshake and an iterative one-bit-per-cycle shifter
// ALU_EXEC_FAST_SHIFT_EN selects a single-cycle barrel shifter instead
module alu_exec #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    import alu_pkg::*;
    state_t state, next;
    logic [SHW-1:0] count;
    logic dir, accept, iter;
    logic [WIDTH-1:0] core_y, load, shifted;

    alu_logic_core #(.WIDTH(WIDTH)) u_core (
        .op(alu_control),
        .a(a_in),
        .b(b_in),
`ifdef ALU_EXEC_FAST_SHIFT_EN
        .shamt(shamt),
`endif
        .y(core_y)
    );

`ifdef ALU_EXEC_FAST_SHIFT_EN
    assign iter = 1'b0;
    assign load = core_y;
`else
    // Shifts load the source operand; the iterator then walks it shamt times
    assign iter = alu_control[2:1] == 2'b11 && shamt != '0;
    assign load = alu_control[2:1] == 2'b11 ? a_in : core_y;
`endif
    assign accept  = start && state != SHIFT;
    assign shifted = dir ? result >> 1 : result << 1;

    always_ff @(posedge clk)
        state <= reset ? IDLE : next;

    always_comb begin
        busy = state == SHIFT;
        done = state == DONE;
        next = state == SHIFT ? (count == SHW'(1) ? DONE : SHIFT)
             : accept ? (iter ? SHIFT : DONE) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b1;
            count  <= '0;
            dir    <= 1'b0;
        end else if (accept) begin
            result <= load;
            zero   <= load == '0;
            count  <= shamt;
            dir    <= alu_control[0];
        end else if (state == SHIFT) begin
            result <= shifted;
            zero   <= shifted == '0;
            count  <= count - SHW'(1);
        end
    end
endmodule
